// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared constants for the bit-serial adder/subtractor: default
//             operand width and the FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder
//  Purpose  : One-bit combinational full adder built from two half-adder
//             stages whose carries are merged by an OR.
//  Revision : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic A,
    input  logic B,
    input  logic CarryIn,
    output logic Sum,
    output logic CarryOut
);

    logic w_ha0_sum;
    logic w_ha0_carry;
    logic w_ha1_carry;

    // First half adder: operand bits
    assign w_ha0_sum   = A ^ B;
    assign w_ha0_carry = A & B;

    // Second half adder: partial sum with incoming carry
    assign Sum         = w_ha0_sum ^ CarryIn;
    assign w_ha1_carry = w_ha0_sum & CarryIn;

    // Either half adder may generate the carry, never both
    assign CarryOut    = w_ha0_carry | w_ha1_carry;

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder/subtractor. One bit is resolved per
//             clock, LSB first; subtraction is A + ~B + 1.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             CarryIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;

    // New work is taken whenever the engine is not mid-operation
    assign w_accept = Start && (state_q != RUN);
    assign w_last   = (cnt_q == CNT_LAST);

    full_adder u_full_adder (
        .A        (a_q[0]),
        .B        (b_q[0]),
        .CarryIn  (carry_q),
        .Sum      (w_fa_sum),
        .CarryOut (w_fa_cout)
    );

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DONE can chain straight into RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = Start ? RUN : IDLE;
            RUN:     state_d = w_last ? DONE : RUN;
            DONE:    state_d = Start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs are pure decodes of the current state
    always_comb begin
        Busy = (state_q == RUN);
        Done = (state_q == DONE);
    end

    // Datapath next-state: load on accept, otherwise one bit step per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (w_accept) begin
            a_d     = A;
            b_d     = Sub ? ~B : B;
            carry_d = Sub | CarryIn;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sum_d   = {w_fa_sum, sum_q[WIDTH-1:1]};
            carry_d = w_fa_cout;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (w_last) begin
                // On the final step carry_q is the carry into the MSB
                cout_d = w_fa_cout;
                ovf_d  = w_fa_cout ^ carry_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Sum      = sum_q;
    assign CarryOut = cout_q;
    assign Overflow = ovf_q;

endmodule : serial_adder
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Clk  input  1  rising-edge clock for all sequential logic.
REQ-003 Reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Start  input  1  request new operation; sampled on rising Clk.
REQ-005 A  input  WIDTH  first operand; sampled when Start is accepted.
REQ-006 B  input  WIDTH  second operand; sampled when Start is accepted.
REQ-007 Sub  input  1  0 = A+B+CarryIn, 1 = A-B; sampled when Start is accepted.
REQ-008 CarryIn  input  1  carry-in for add mode; ignored when Sub=1.
REQ-009 Busy  output  1  high while an operation is in progress.
REQ-010 Done  output  1  one-cycle pulse: result valid.
REQ-011 Sum  output  WIDTH  result; held stable from Done until the next accepted Start.
REQ-012 CarryOut  output  1  carry out of MSB; in subtract mode 1 = no borrow.
REQ-013 Overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 Start is accepted only in IDLE or DONE; Start in RUN is ignored with no side effect.
REQ-016 On acceptance, the block latches A, B, Sub and carry-in, clears the bit counter and enters RUN. Carry-in = 1 if Sub, else CarryIn. B is latched inverted if Sub.
REQ-017 In RUN, each rising edge runs one full-adder step on the operand LSBs and the carry register, then shifts the result bit into Sum MSB-first-in (LSB resolved first).
REQ-018 In RUN, each step updates the carry register, shifts both operands right by one and increments the counter.
REQ-019 The counter is $clog2(WIDTH) bits. After exactly WIDTH RUN steps the FSM enters DONE.
REQ-020 Latency: if Start is accepted at edge t, Done = 1 during the cycle after edge t+WIDTH. Busy = 1 after edges t..t+WIDTH-1.
REQ-021 DONE lasts one cycle and returns to IDLE unless Start is accepted, which enters RUN directly. Back-to-back operations take WIDTH+1 cycles each.
REQ-022 Sum, CarryOut and Overflow are registered. They change only during RUN and hold their final values in DONE and IDLE.
REQ-023 Before the final step, the block captures the carry into the MSB so that Overflow is computed at the final edge.
REQ-024 During RUN, Sum holds partial shifted data; its value is defined only from Done onward.

Reset
REQ-025 Reset_n low asynchronously forces: IDLE, Busy=0, Done=0, Sum=0, CarryOut=0, Overflow=0, counter=0, carry register=0, operand registers=0.
REQ-026 Reset asserted mid-RUN aborts the operation; no Done is produced.
REQ-027 After Reset_n deasserts, the first Start on a rising edge is accepted normally.

Structure
REQ-028 Shared package serial_adder_pkg holds the FSM state encoding (2-bit localparams IDLE/RUN/DONE) and the default WIDTH constant.
REQ-029 A single sub-module full_adder (A, B, CarryIn -> Sum, CarryOut; combinational) is instantiated once for the bit step. It is composed of two half-adder stages plus OR.
REQ-030 No other sub-modules; the datapath is two WIDTH-bit shift registers, one WIDTH-bit result shift register, a carry flop and a counter.

Verification (WIDTH=8)
REQ-031 Add 0x0F+0x01, CarryIn=0 -> Done 8 cycles after the Start edge; Sum=0x10, CarryOut=0, Overflow=0.
REQ-032 Add 0xFF+0x01, CarryIn=0 -> Sum=0x00, CarryOut=1, Overflow=0. Add 0x7F+0x00, CarryIn=1 -> Sum=0x80, CarryOut=0, Overflow=1.
REQ-033 Sub 0x05-0x07 -> Sum=0xFE, CarryOut=0, Overflow=0. Sub 0x80-0x01 -> Sum=0x7F, CarryOut=1, Overflow=1.
REQ-034 Start pulsed at cycle 3 of RUN with different operands -> ignored; the original result is delivered, with exactly one Done.
REQ-035 Reset_n pulsed low at cycle 4 of RUN -> all outputs 0 immediately, no Done. A subsequent 0x01+0x01 yields Sum=0x02.
REQ-036 Start held high through DONE -> next operation starts without an IDLE cycle; two Done pulses spaced 9 cycles apart, each with the correct Sum.
